score_timer: RTL and testbench

- Parametrised successor to the ad-hoc frame/score counter in the game top level.
- Converts the vblank level (frame_clk) into a one-cycle frame tick and runs a game-phase FSM (IDLE/RUN/PAUSE/OVER).
- Accumulates a saturating BCD score from elapsed frames plus per-jump bonus points.
- Feeds the drawing engine's score digits and the game_state block.

---
 rtl/score_timer_pkg.sv | 23 ++
 rtl/score_timer_bcd_add_digit.sv | 26 ++
 rtl/score_timer.sv | 177 +++++++++++++++++
 tb/tb_score_timer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_timer_pkg.sv
// Shared types and constants for the score timer: game phases, BCD digits, all-9s helper.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } phase_t;

  typedef logic [3:0] bcd_digit_t;

  // All-9s BCD value for n digits (up to 16 digits), digit 0 in the LSBs.
  function automatic logic [63:0] bcd_max(input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_timer_bcd_add_digit.sv
// One BCD digit adder stage: a + b + cin with decimal carry-out.
module bcd_add_digit
  import score_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);

  logic [4:0] raw;
  logic [4:0] adj;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    adj  = raw - 5'd10;
    sum  = raw[3:0];
    cout = 1'b0;
    if (raw > 5'd9) begin
      sum  = adj[3:0];
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/score_timer.sv
// Frame-tick generator, game-phase FSM and saturating BCD score accumulator.
// Optional best-score tracking is built only when SCORE_TIMER_HISCORE_EN is defined.
module score_timer
  import score_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int FRAMES_PER_PT = 60,
  parameter int JUMP_PTS      = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    game_over,
  input  logic                    jump_pulse,
  output logic                    frame_tick,
  output logic [1:0]              phase,
  output logic [4*NUM_DIGITS-1:0] score,
  output logic [4*NUM_DIGITS-1:0] hiscore,
  output logic                    new_record
);

  localparam int                SW        = 4 * NUM_DIGITS;
  localparam logic [SW-1:0]     SCORE_MAX = SW'(bcd_max(NUM_DIGITS));
  localparam logic [7:0]        FC_LAST   = 8'(FRAMES_PER_PT - 1);
  localparam logic [3:0]        JUMP_BCD  = 4'(JUMP_PTS);

  phase_t        phase_q, phase_d;
  logic          s0_q, s0_d, s1_q, s1_d, tick_q, tick_d;
  logic [7:0]    fc_q, fc_d, fc_next;
  logic [SW-1:0] score_q, score_d;
  logic          time_pt;
  logic [4:0]    add_bin;
  logic [7:0]    add_bcd;
  logic [SW-1:0] addend, sum, sat_sum;
  logic [NUM_DIGITS:0] carry;

  // Frame counter step and the 0..10 addend expressed as two BCD digits.
  always_comb begin
    time_pt = 1'b0;
    fc_next = fc_q;
    if (tick_q) begin
      if (fc_q >= FC_LAST) begin
        fc_next = '0;
        time_pt = 1'b1;
      end else begin
        fc_next = fc_q + 8'd1;
      end
    end
    add_bin = {4'b0, time_pt} + (jump_pulse ? {1'b0, JUMP_BCD} : 5'd0);
    add_bcd = {4'd0, add_bin[3:0]};
    if (add_bin >= 5'd10) add_bcd = {4'd1, 4'(add_bin - 5'd10)};
    addend  = SW'(add_bcd);
  end

  assign carry[0] = 1'b0;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_add_digit u_digit (
      .a    (score_q[4*g +: 4]),
      .b    (addend[4*g +: 4]),
      .cin  (carry[g]),
      .sum  (sum[4*g +: 4]),
      .cout (carry[g+1])
    );
  end

  // A carry out of the top digit means overflow: pin at all 9s.
  assign sat_sum = carry[NUM_DIGITS] ? SCORE_MAX : sum;

  always_comb begin
    s0_d    = frame_clk;
    s1_d    = s0_q;
    tick_d  = s0_q & ~s1_q;
    phase_d = phase_q;
    fc_d    = fc_q;
    score_d = score_q;
    case (phase_q)
      IDLE: begin
        if (start) begin
          phase_d = RUN;
          fc_d    = '0;
          score_d = '0;
        end
      end
      RUN: begin
        if (game_over) begin
          phase_d = OVER;
        end else if (start) begin
          fc_d    = '0;
          score_d = '0;
        end else if (pause) begin
          phase_d = PAUSE;
        end else begin
          fc_d    = fc_next;
          score_d = sat_sum;
        end
      end
      PAUSE: begin
        if (game_over) begin
          phase_d = OVER;
        end else if (start) begin
          phase_d = RUN;
          fc_d    = '0;
          score_d = '0;
        end else if (!pause) begin
          phase_d = RUN;
        end
      end
      OVER: begin
        if (!game_over && start) begin
          phase_d = RUN;
          fc_d    = '0;
          score_d = '0;
        end
      end
      default: phase_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      phase_q <= IDLE;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      tick_q  <= 1'b0;
      fc_q    <= '0;
      score_q <= '0;
    end else begin
      phase_q <= phase_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      tick_q  <= tick_d;
      fc_q    <= fc_d;
      score_q <= score_d;
    end
  end

  assign frame_tick = tick_q;
  assign phase      = phase_q;
  assign score      = score_q;

`ifdef SCORE_TIMER_HISCORE_EN
  logic          entry_q, entry_d, new_record_q, new_record_d;
  logic [SW-1:0] hiscore_q, hiscore_d;

  // Valid BCD orders the same as binary, so a packed compare is an MSD-first compare.
  always_comb begin
    entry_d      = (phase_d == OVER) && (phase_q != OVER);
    hiscore_d    = hiscore_q;
    new_record_d = 1'b0;
    if (entry_q && (score_q > hiscore_q)) begin
      hiscore_d    = score_q;
      new_record_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      entry_q      <= 1'b0;
      hiscore_q    <= '0;
      new_record_q <= 1'b0;
    end else begin
      entry_q      <= entry_d;
      hiscore_q    <= hiscore_d;
      new_record_q <= new_record_d;
    end
  end

  assign hiscore    = hiscore_q;
  assign new_record = new_record_q;
`else
  assign hiscore    = '0;
  assign new_record = 1'b0;
`endif

endmodule

// File: tb/tb_score_timer.sv
// Self-checking bench for score_timer: cycle model feeds a scoreboard queue,
// plus directed checks of the key score/phase milestones.
module tb_score_timer;

  localparam int FPP  = 60;
  localparam int JP   = 1;
  localparam int MAXV = 9999;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_clk = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        game_over = 1'b0;
  logic        jump_pulse = 1'b0;
  logic        frame_tick;
  logic [1:0]  phase;
  logic [15:0] score;
  logic [15:0] hiscore;
  logic        new_record;

  typedef struct {
    logic [1:0]  phase;
    logic [15:0] score;
    logic        tick;
    logic [15:0] hi;
    logic        nr;
  } exp_t;

  exp_t exp_q[$];

  int compared   = 0;
  int mismatched = 0;
  int tick_seen  = 0;
  int nr_seen    = 0;

  int   m_phase = 0, m_score = 0, m_fc = 0, m_hi = 0;
  logic m_s0 = 0, m_s1 = 0, m_tick = 0, m_entry = 0, m_nr = 0;

  score_timer #(.NUM_DIGITS(4), .FRAMES_PER_PT(FPP), .JUMP_PTS(JP)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .start      (start),
    .pause      (pause),
    .game_over  (game_over),
    .jump_pulse (jump_pulse),
    .frame_tick (frame_tick),
    .phase      (phase),
    .score      (score),
    .hiscore    (hiscore),
    .new_record (new_record)
  );

  always #10 Clk = ~Clk;

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = exp_q.pop_front();
    if (frame_tick === 1'b1) tick_seen++;
    if (new_record === 1'b1) nr_seen++;
    checkValue("phase", {14'b0, phase}, {14'b0, e.phase});
    checkValue("score", score, e.score);
    checkValue("frame_tick", {15'b0, frame_tick}, {15'b0, e.tick});
    checkValue("hiscore", hiscore, e.hi);
    checkValue("new_record", {15'b0, new_record}, {15'b0, e.nr});
  endtask

  // Drive one cycle of inputs, predict the post-edge state, then compare after the edge.
  task automatic applyStimulus(input logic rst, input logic fc, input logic st,
                               input logic pa, input logic go, input logic jp);
    int   n_phase, n_score, n_fc, n_hi, tp, addv;
    logic n_s0, n_s1, n_tick, n_entry, n_nr;
    exp_t e;
    @(negedge Clk);
    Reset = rst; frame_clk = fc; start = st; pause = pa; game_over = go; jump_pulse = jp;
    n_s0 = fc; n_s1 = m_s0; n_tick = m_s0 & ~m_s1;
    n_phase = m_phase; n_score = m_score; n_fc = m_fc;
    case (m_phase)
      0: if (st) begin n_phase = 1; n_score = 0; n_fc = 0; end
      1: begin
        if (go) n_phase = 3;
        else if (st) begin n_score = 0; n_fc = 0; end
        else if (pa) n_phase = 2;
        else begin
          tp = 0;
          if (m_tick) begin
            if (m_fc == FPP - 1) begin n_fc = 0; tp = 1; end
            else n_fc = m_fc + 1;
          end
          addv = tp + (jp ? JP : 0);
          n_score = (m_score + addv > MAXV) ? MAXV : m_score + addv;
        end
      end
      2: begin
        if (go) n_phase = 3;
        else if (st) begin n_phase = 1; n_score = 0; n_fc = 0; end
        else if (!pa) n_phase = 1;
      end
      default: if (!go && st) begin n_phase = 1; n_score = 0; n_fc = 0; end
    endcase
    n_entry = (n_phase == 3) && (m_phase != 3);
    n_hi = m_hi; n_nr = 1'b0;
`ifdef SCORE_TIMER_HISCORE_EN
    if (m_entry && (m_score > m_hi)) begin n_hi = m_score; n_nr = 1'b1; end
`endif
    if (rst) begin
      n_phase = 0; n_score = 0; n_fc = 0; n_hi = 0;
      n_s0 = 0; n_s1 = 0; n_tick = 0; n_entry = 0; n_nr = 0;
    end
    m_phase = n_phase; m_score = n_score; m_fc = n_fc; m_hi = n_hi;
    m_s0 = n_s0; m_s1 = n_s1; m_tick = n_tick; m_entry = n_entry; m_nr = n_nr;
    e.phase = 2'(m_phase); e.score = to_bcd(m_score); e.tick = m_tick;
    e.hi = to_bcd(m_hi); e.nr = m_nr;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    checkOutput();
  endtask

  // One frame: three cycles high, three low; optional jump on the cycle the tick is scored.
  task automatic doFrame(input logic pa, input logic go, input logic jp_on_tick);
    for (int c = 0; c < 6; c++)
      applyStimulus(1'b0, c < 3, 1'b0, pa, go, jp_on_tick && (c == 2));
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic jumps(input int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    $display("[TB] score_timer bench start");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("reset_phase", {14'b0, phase}, 16'd0);
    checkValue("reset_score", score, 16'h0000);
    checkValue("reset_tick", {15'b0, frame_tick}, 16'd0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("start_phase", {14'b0, phase}, 16'd1);
    tick_seen = 0;
    for (int f = 0; f < 60; f++) doFrame(1'b0, 1'b0, 1'b0);
    checkValue("ticks_60", 16'(tick_seen), 16'd60);
    checkValue("score_60_frames", score, 16'h0001);

    jumps(8);
    for (int f = 0; f < 59; f++) doFrame(1'b0, 1'b0, 1'b0);
    checkValue("score_before_carry", score, 16'h0009);
    doFrame(1'b0, 1'b0, 1'b1);
    checkValue("score_bcd_carry", score, 16'h0011);

    for (int f = 0; f < 30; f++) doFrame(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 100; f++) doFrame(1'b1, 1'b0, 1'b1);
    checkValue("pause_phase", {14'b0, phase}, 16'd2);
    checkValue("pause_score", score, 16'h0011);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 29; f++) doFrame(1'b0, 1'b0, 1'b0);
    checkValue("resume_frozen_count", score, 16'h0011);
    doFrame(1'b0, 1'b0, 1'b0);
    checkValue("resume_wrap", score, 16'h0012);

    for (int c = 0; c < 10000 && m_score < 9998; c++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    checkValue("preload_9998", score, 16'h9998);
    for (int j = 0; j < 3; j++) begin
      jumps(1);
      checkValue("saturate_9999", score, 16'h9999);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkValue("over_phase", {14'b0, phase}, 16'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkValue("start_with_over", {14'b0, phase}, 16'd3);
    idle(2);
    for (int f = 0; f < 3; f++) doFrame(1'b0, 1'b0, 1'b1);
    checkValue("over_frozen_score", score, 16'h9999);
    checkValue("over_frozen_phase", {14'b0, phase}, 16'd3);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("reset_in_over_hi", hiscore, 16'h0000);
    nr_seen = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 42; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
`ifdef SCORE_TIMER_HISCORE_EN
    checkValue("game1_hiscore", hiscore, 16'h0042);
    checkValue("game1_record", 16'(nr_seen), 16'd1);
`else
    checkValue("game1_hiscore_off", hiscore, 16'h0000);
    checkValue("game1_record_off", 16'(nr_seen), 16'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("restart_score", score, 16'h0000);
    for (int c = 0; c < 30; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    checkValue("game2_score", score, 16'h0030);
`ifdef SCORE_TIMER_HISCORE_EN
    checkValue("game2_hiscore", hiscore, 16'h0042);
    checkValue("game2_record", 16'(nr_seen), 16'd1);
`else
    checkValue("game2_hiscore_off", hiscore, 16'h0000);
    checkValue("game2_record_off", 16'(nr_seen), 16'd0);
`endif

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 123; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    checkValue("midrun_score", score, 16'h0123);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("midrun_reset_phase", {14'b0, phase}, 16'd0);
    checkValue("midrun_reset_score", score, 16'h0000);
    checkValue("midrun_reset_hi", hiscore, 16'h0000);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
